// File: rtl/audio_pkg.sv
// Shared definitions for the serial audio receiver and transmitter:
// default sample width, receiver state encoding and a counter-sizing helper.
package audio_pkg;

   localparam int AUDIO_WIDTH = 24;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_SYNC  = 2'd1;
   localparam logic [1:0] ST_LEFT  = 2'd2;
   localparam logic [1:0] ST_RIGHT = 2'd3;

   // Bits needed to hold the values 0..n inclusive.
   function automatic int cnt_width(input int n);
      return (n < 1) ? 1 : $clog2(n + 1);
   endfunction

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchroniser for an asynchronous level, plus single-clk
// rising/falling edge strobes derived from the synchronised value.
module sync_edge (
   input  logic clk,
   input  logic nReset,
   input  logic i_d,
   output logic o_q,
   output logic o_rise,
   output logic o_fall
);

   logic r_meta;
   logic r_q;
   logic r_q_d;

   always_ff @(posedge clk or negedge nReset) begin
      if (!nReset) begin
         r_meta <= 1'b0;
         r_q    <= 1'b0;
         r_q_d  <= 1'b0;
      end else begin
         r_meta <= i_d;
         r_q    <= r_meta;
         r_q_d  <= r_q;
      end
   end

   assign o_q    = r_q;
   assign o_rise = r_q & ~r_q_d;
   assign o_fall = ~r_q & r_q_d;

endmodule

// File: rtl/adc_receiver.sv
// I2S / left-justified serial audio receiver oversampling sclk in the clk domain;
// emits a one-clk valid with a left/right pair one clk after the closing sclk edge.
module adc_receiver
   import audio_pkg::*;
#(
   parameter int WIDTH     = AUDIO_WIDTH,
   parameter int BIT_DELAY = 1
) (
   input  logic             clk,
   input  logic             nReset,
   input  logic             enable,
   input  logic             sclk,
   input  logic             lrclk,
   input  logic             sd,
   output logic [WIDTH-1:0] left_data,
   output logic [WIDTH-1:0] right_data,
   output logic             valid,
   output logic             overrun
);

   localparam int CNT_MAX = WIDTH + BIT_DELAY;
   localparam int CW      = cnt_width(CNT_MAX);
   localparam int NW      = cnt_width(WIDTH);
   localparam logic [CW-1:0] CNT_SAT  = CW'(CNT_MAX);
   localparam logic [CW-1:0] CNT_SKIP = CW'(BIT_DELAY);
   localparam logic [NW-1:0] NB_FULL  = NW'(WIDTH);

   logic w_sclk_q, w_sclk_rise, w_sclk_fall;
   logic w_lr_q, w_lr_rise, w_lr_fall;
   logic w_unused;

   logic r_sd_meta, r_sd_q;
   logic r_lr_prev;

   logic [1:0]       r_state;
   logic [CW-1:0]    r_cnt;
   logic [NW-1:0]    r_nbits;
   logic [WIDTH-1:0] r_shift;
   logic [WIDTH-1:0] r_hold;
   logic [WIDTH-1:0] r_left;
   logic [WIDTH-1:0] r_right;
   logic             r_valid;
   logic             r_overrun;

   logic             w_lr_s_fall, w_lr_s_rise;
   logic             w_new_ch, w_is_data, w_is_over;
   logic [CW-1:0]    w_cnt_base, w_cnt_next;
   logic [NW-1:0]    w_nbits_base, w_nbits_next;
   logic [WIDTH-1:0] w_shift_base, w_shift_next, w_word;

   sync_edge u_sync_sclk (
      .clk    (clk),
      .nReset (nReset),
      .i_d    (sclk),
      .o_q    (w_sclk_q),
      .o_rise (w_sclk_rise),
      .o_fall (w_sclk_fall)
   );

   sync_edge u_sync_lrclk (
      .clk    (clk),
      .nReset (nReset),
      .i_d    (lrclk),
      .o_q    (w_lr_q),
      .o_rise (w_lr_rise),
      .o_fall (w_lr_fall)
   );

   // Channel boundaries are judged on sclk-sampled lrclk, so the raw strobes go unused.
   assign w_unused = w_sclk_q ^ w_sclk_fall ^ w_lr_rise ^ w_lr_fall;

   // sd takes the same two-flop path as sclk, so it lines up with w_sclk_rise.
   always_ff @(posedge clk or negedge nReset) begin
      if (!nReset) begin
         r_sd_meta <= 1'b0;
         r_sd_q    <= 1'b0;
      end else begin
         r_sd_meta <= sd;
         r_sd_q    <= r_sd_meta;
      end
   end

   // Tracked even while idle so SYNC never acts on a stale lrclk sample.
   always_ff @(posedge clk or negedge nReset) begin
      if (!nReset) begin
         r_lr_prev <= 1'b0;
      end else if (w_sclk_rise) begin
         r_lr_prev <= w_lr_q;
      end
   end

   assign w_lr_s_fall = r_lr_prev & ~w_lr_q;
   assign w_lr_s_rise = ~r_lr_prev & w_lr_q;

   always_comb begin
      w_new_ch = 1'b0;
      case (r_state)
         ST_SYNC, ST_RIGHT: w_new_ch = w_lr_s_fall;
         ST_LEFT:           w_new_ch = w_lr_s_rise;
         default:           w_new_ch = 1'b0;
      endcase
   end

   // The edge that opens a channel is also its sample 0, processed from a cleared state.
   assign w_cnt_base   = w_new_ch ? '0 : r_cnt;
   assign w_nbits_base = w_new_ch ? '0 : r_nbits;
   assign w_shift_base = w_new_ch ? '0 : r_shift;

   assign w_is_data    = (w_cnt_base >= CNT_SKIP) && (w_cnt_base < CNT_SAT);
   assign w_is_over    = (w_cnt_base == CNT_SAT);
   assign w_cnt_next   = w_is_over ? w_cnt_base : w_cnt_base + CW'(1);
   assign w_nbits_next = w_is_data ? w_nbits_base + NW'(1) : w_nbits_base;
   assign w_shift_next = w_is_data ? {w_shift_base[WIDTH-2:0], r_sd_q} : w_shift_base;

   // Short channels are left-aligned with zero LSBs.
   assign w_word = r_shift << (NB_FULL - r_nbits);

   always_ff @(posedge clk or negedge nReset) begin
      if (!nReset) begin
         r_state   <= ST_IDLE;
         r_cnt     <= '0;
         r_nbits   <= '0;
         r_shift   <= '0;
         r_hold    <= '0;
         r_left    <= '0;
         r_right   <= '0;
         r_valid   <= 1'b0;
         r_overrun <= 1'b0;
      end else begin
         r_valid <= 1'b0;
         if (!enable) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_nbits <= '0;
            r_shift <= '0;
         end else begin
            case (r_state)
               ST_IDLE: begin
                  r_state <= ST_SYNC;
               end
               ST_SYNC: begin
                  if (w_sclk_rise && w_new_ch) begin
                     r_state <= ST_LEFT;
                     r_cnt   <= w_cnt_next;
                     r_nbits <= w_nbits_next;
                     r_shift <= w_shift_next;
                  end
               end
               ST_LEFT, ST_RIGHT: begin
                  if (w_sclk_rise) begin
                     r_cnt   <= w_cnt_next;
                     r_nbits <= w_nbits_next;
                     r_shift <= w_shift_next;
                     if (w_is_over) begin
                        r_overrun <= 1'b1;
                     end
                     if (w_new_ch) begin
                        if (r_state == ST_LEFT) begin
                           r_hold  <= w_word;
                           r_state <= ST_RIGHT;
                        end else begin
                           r_left  <= r_hold;
                           r_right <= w_word;
                           r_valid <= 1'b1;
                           r_state <= ST_LEFT;
                        end
                     end
                  end
               end
               default: begin
                  r_state <= ST_IDLE;
               end
            endcase
         end
      end
   end

   assign left_data  = r_left;
   assign right_data = r_right;
   assign valid      = r_valid;
   assign overrun    = r_overrun;

endmodule

// File: tb/tb_adc_receiver.sv
// Directed bench for adc_receiver: bit-level serial source model driving
// 24/16/32-bit frames, enable drop and mid-word reset scenarios.
module tb_adc_receiver;

   logic        clk;
   logic        nReset;
   logic        enable;
   logic        sclk;
   logic        lrclk;
   logic        sd;
   logic [23:0] left_data;
   logic [23:0] right_data;
   logic        valid;
   logic        overrun;

   int n_chk = 0;
   int n_err = 0;

   int          vcount;
   int          n_new;
   int          n_bad;
   int          n_wide = 0;
   logic        prev_valid = 1'b0;
   logic [23:0] first_l, first_r, last_l, last_r;
   logic [23:0] ok_l0, ok_r0, ok_l1, ok_r1;

   adc_receiver #(.WIDTH(24), .BIT_DELAY(1)) dut (
      .clk        (clk),
      .nReset     (nReset),
      .enable     (enable),
      .sclk       (sclk),
      .lrclk      (lrclk),
      .sd         (sd),
      .left_data  (left_data),
      .right_data (right_data),
      .valid      (valid),
      .overrun    (overrun)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   // Pair monitor: ok_*1 is the "new" pair, ok_*0 the other acceptable pair.
   always @(negedge clk) begin
      if (valid) begin
         vcount++;
         if (vcount == 1) begin
            first_l = left_data;
            first_r = right_data;
         end
         last_l = left_data;
         last_r = right_data;
         if (left_data == ok_l1 && right_data == ok_r1) n_new++;
         else if (!(left_data == ok_l0 && right_data == ok_r0)) n_bad++;
         if (prev_valid) n_wide++;
      end
      prev_valid = valid;
   end

   task automatic expect_pairs(input logic [23:0] l0, input logic [23:0] r0,
                               input logic [23:0] l1, input logic [23:0] r1);
      ok_l0 = l0; ok_r0 = r0; ok_l1 = l1; ok_r1 = r1;
      vcount = 0; n_new = 0; n_bad = 0;
   endtask

   // One sclk period (8 clk); lrclk and sd change with the falling sclk edge.
   task automatic slot(input logic lr, input logic b);
      sclk = 1'b0; lrclk = lr; sd = b;
      repeat (4) @(negedge clk);
      sclk = 1'b1;
      repeat (4) @(negedge clk);
   endtask

   task automatic send_chan(input logic lr, input logic [31:0] w, input int n);
      slot(lr, 1'b0);
      for (int i = n - 1; i >= 0; i--) slot(lr, w[i]);
   endtask

   task automatic send_frames(input logic [31:0] l, input logic [31:0] r, input int n, input int count);
      for (int k = 0; k < count; k++) begin
         send_chan(1'b0, l, n);
         send_chan(1'b1, r, n);
      end
   endtask

   // Opens the next left channel so the last right word gets committed.
   task automatic flush();
      slot(1'b0, 1'b0);
      repeat (6) @(negedge clk);
   endtask

   task automatic restart();
      enable = 1'b0;
      repeat (3) @(negedge clk);
      enable = 1'b1;
      repeat (3) @(negedge clk);
   endtask

   initial begin
      nReset = 1'b0; enable = 1'b0; sclk = 1'b0; lrclk = 1'b0; sd = 1'b0;
      expect_pairs(24'h0, 24'h0, 24'h0, 24'h0);
      repeat (4) @(negedge clk);
      check("rst_left", left_data, 24'h0);
      check("rst_right", right_data, 24'h0);
      check("rst_valid", valid, 1'b0);
      check("rst_overrun", overrun, 1'b0);
      nReset = 1'b1;
      repeat (2) @(negedge clk);
      enable = 1'b1;
      repeat (3) @(negedge clk);

      // Full-scale pair, then a mid-run switch to new data.
      expect_pairs(24'hFFFFFF, 24'h000000, 24'h010101, 24'h101010);
      send_frames(32'hFFFFFF, 32'h000000, 24, 3);
      send_frames(32'h010101, 32'h101010, 24, 3);
      flush();
      check("a_vcount", vcount, 5);
      check("a_first_l", first_l, 24'hFFFFFF);
      check("a_first_r", first_r, 24'h000000);
      check("a_n_new", n_new, 3);
      check("a_mixed", n_bad, 0);
      check("a_last_l", last_l, 24'h010101);
      check("a_last_r", last_r, 24'h101010);
      check("a_overrun", overrun, 1'b0);

      // 16-bit channels: left-aligned, zero padded.
      restart();
      expect_pairs(24'hABCD00, 24'h123400, 24'hABCD00, 24'h123400);
      send_frames(32'hABCD, 32'h1234, 16, 3);
      flush();
      check("b_vcount", vcount, 2);
      check("b_last_l", last_l, 24'hABCD00);
      check("b_last_r", last_r, 24'h123400);
      check("b_bad", n_bad, 0);
      check("b_overrun", overrun, 1'b0);

      // enable dropped for 10 clk during a right word.
      restart();
      expect_pairs(24'h123456, 24'h654321, 24'h0F0F0F, 24'hF0F0F0);
      send_frames(32'h123456, 32'h654321, 24, 3);
      fork
         send_frames(32'hAAAAAA, 32'h555555, 24, 1);
         begin
            repeat (25 * 8 + 40) @(negedge clk);
            enable = 1'b0;
            repeat (10) @(negedge clk);
            enable = 1'b1;
            repeat (2) @(negedge clk);
            check("c_hold_l", left_data, 24'h123456);
            check("c_hold_r", right_data, 24'h654321);
         end
      join
      send_frames(32'h0F0F0F, 32'hF0F0F0, 24, 2);
      flush();
      check("c_vcount", vcount, 4);
      check("c_n_new", n_new, 2);
      check("c_dropped", n_bad, 0);
      check("c_last_l", last_l, 24'h0F0F0F);

      // 32-bit channels: truncated to the top 24 bits, overrun latched.
      restart();
      expect_pairs(24'hDEADBE, 24'h012345, 24'hDEADBE, 24'h012345);
      send_frames(32'hDEADBEEF, 32'h01234567, 32, 2);
      flush();
      check("d_vcount", vcount, 1);
      check("d_last_l", last_l, 24'hDEADBE);
      check("d_last_r", last_r, 24'h012345);
      check("d_overrun", overrun, 1'b1);

      // Reset pulsed mid-left-word.
      restart();
      expect_pairs(24'h111111, 24'h222222, 24'h111111, 24'h222222);
      send_frames(32'h111111, 32'h222222, 24, 2);
      flush();
      check("e_pre_vcount", vcount, 1);
      check("e_pre_left", left_data, 24'h111111);
      check("e_overrun_sticky", overrun, 1'b1);
      fork
         send_frames(32'h333333, 32'hCCCCCC, 24, 1);
         begin
            repeat (40) @(negedge clk);
            nReset = 1'b0;
            repeat (2) @(negedge clk);
            check("e_rst_left", left_data, 24'h0);
            check("e_rst_right", right_data, 24'h0);
            check("e_rst_valid", valid, 1'b0);
            check("e_rst_overrun", overrun, 1'b0);
            nReset = 1'b1;
            expect_pairs(24'h444444, 24'h555555, 24'h444444, 24'h555555);
         end
      join
      send_frames(32'h444444, 32'h555555, 24, 3);
      flush();
      check("e_vcount", vcount, 3);
      check("e_first_l", first_l, 24'h444444);
      check("e_first_r", first_r, 24'h555555);
      check("e_bad", n_bad, 0);
      check("e_overrun", overrun, 1'b0);

      check("valid_width", n_wide, 0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
